rtttl_tone_generator: RTL

Converts the `{octave, note}` pair from `rtttl_sequencer` into a 50 % duty square wave that drives the piezo/speaker pin. It sits directly downstream of the sequencer. It runs on the same 1 MHz `clk`. A change in the pitch pair restarts the waveform cleanly, and rests or invalid notes hold the output low.

---
 rtl/rtttl_pkg.sv | 42 ++++
 rtl/rtttl_note_period.sv | 31 +++
 rtl/rtttl_tone_generator.sv | 81 ++++++++
 3 files changed

// File: rtl/rtttl_pkg.sv
// Shared RTTTL pitch definitions: note encoding, octave limits and the
// octave-4 half-period table for a 1 MHz clock.
package rtttl_pkg;

  localparam logic [3:0] NOTE_REST = 4'd0;
  localparam logic [3:0] NOTE_C    = 4'd1;
  localparam logic [3:0] NOTE_CS   = 4'd2;
  localparam logic [3:0] NOTE_D    = 4'd3;
  localparam logic [3:0] NOTE_DS   = 4'd4;
  localparam logic [3:0] NOTE_E    = 4'd5;
  localparam logic [3:0] NOTE_F    = 4'd6;
  localparam logic [3:0] NOTE_FS   = 4'd7;
  localparam logic [3:0] NOTE_G    = 4'd8;
  localparam logic [3:0] NOTE_GS   = 4'd9;
  localparam logic [3:0] NOTE_A    = 4'd10;
  localparam logic [3:0] NOTE_AS   = 4'd11;
  localparam logic [3:0] NOTE_B    = 4'd12;

  localparam logic [3:0] OCT_MIN = 4'd4;
  localparam logic [3:0] OCT_MAX = 4'd7;

  localparam int CLK_HZ = 1_000_000;
  localparam int BASE_W = 11;

  // Half-periods in clk cycles for octave 4, C first.
  localparam logic [BASE_W-1:0] BASE_HALF_PERIOD [12] = '{
    11'd1911, 11'd1804, 11'd1703, 11'd1607, 11'd1517, 11'd1432,
    11'd1351, 11'd1276, 11'd1204, 11'd1136, 11'd1073, 11'd1012
  };

  function automatic logic note_is_valid(input logic [3:0] note);
    return (note >= NOTE_C) && (note <= NOTE_B);
  endfunction

  // Invalid notes map to the C entry so the period is never zero.
  function automatic logic [BASE_W-1:0] base_half_period(input logic [3:0] note);
    logic [3:0] idx;
    idx = note_is_valid(note) ? (note - NOTE_C) : 4'd0;
    return BASE_HALF_PERIOD[idx];
  endfunction

endpackage

// File: rtl/rtttl_note_period.sv
// Combinational pitch lookup: clamps the octave to 4..7 and returns the
// half-period in clk cycles for the given note.
module rtttl_note_period
  import rtttl_pkg::*;
#(
  parameter int CNT_W = 11
) (
  input  logic [3:0]       octave,
  input  logic [3:0]       note,
  output logic [CNT_W-1:0] half_period
);

  logic [3:0]        oct_clamped;
  logic [1:0]        shift;
  logic [BASE_W-1:0] base;
  logic [BASE_W-1:0] scaled;

  always_comb begin
    oct_clamped = octave;
    if (octave < OCT_MIN) begin
      oct_clamped = OCT_MIN;
    end else if (octave > OCT_MAX) begin
      oct_clamped = OCT_MAX;
    end
    shift       = 2'(oct_clamped - OCT_MIN);
    base        = base_half_period(note);
    scaled      = base >> shift;
    half_period = CNT_W'(scaled);
  end

endmodule

// File: rtl/rtttl_tone_generator.sv
// Square-wave tone generator: latches the sequencer pitch pair, restarts the
// waveform on any change and toggles the output every half-period.
module rtttl_tone_generator
  import rtttl_pkg::*;
#(
  parameter int CNT_W = 11
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [3:0] octave,
  input  logic [3:0] note,
  output logic       tone,
  output logic       active
);

  logic [3:0]       cur_oct_q, cur_oct_d;
  logic [3:0]       cur_note_q, cur_note_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tone_q, tone_d;
  logic             active_q, active_d;

  logic [CNT_W-1:0] half_period;
  logic             pitch_change;

  rtttl_note_period #(
    .CNT_W (CNT_W)
  ) u_note_period (
    .octave      (cur_oct_q),
    .note        (cur_note_q),
    .half_period (half_period)
  );

  assign pitch_change = {octave, note} != {cur_oct_q, cur_note_q};

  always_comb begin
    cur_oct_d  = cur_oct_q;
    cur_note_d = cur_note_q;
    cnt_d      = cnt_q;
    tone_d     = tone_q;
    active_d   = active_q;
    // A change takes priority over a terminal-count toggle on the same edge.
    if (pitch_change) begin
      cur_oct_d  = octave;
      cur_note_d = note;
      cnt_d      = '0;
      tone_d     = 1'b0;
      active_d   = note_is_valid(note);
    end else if (note_is_valid(cur_note_q)) begin
      if (cnt_q == half_period - CNT_W'(1)) begin
        cnt_d  = '0;
        tone_d = ~tone_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d    = '0;
      tone_d   = 1'b0;
      active_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cur_oct_q  <= '0;
      cur_note_q <= NOTE_REST;
      cnt_q      <= '0;
      tone_q     <= 1'b0;
      active_q   <= 1'b0;
    end else begin
      cur_oct_q  <= cur_oct_d;
      cur_note_q <= cur_note_d;
      cnt_q      <= cnt_d;
      tone_q     <= tone_d;
      active_q   <= active_d;
    end
  end

  assign tone   = tone_q;
  assign active = active_q;

endmodule
